// File: rtl/i2c_responder.sv
// I2C target: 7-bit address, byte write and read with ACK handling, open-drain sda.
// Define I2C_RESPONDER_FILTER_EN to add a 3-sample majority glitch filter on scl/sda.
//
// state    | meaning
// IDLE     | bus ignored until START
// ADDR     | shifting in address + R/W
// ADDR_ACK | acknowledging our address
// WR_DATA  | shifting in a write byte
// WR_ACK   | acknowledging a write byte
// RD_DATA  | shifting out a read byte
// RD_ACK   | sampling the master's ACK/NACK
module i2c_responder #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'h2A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic [7:0] data_received,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
   } state_t;

   state_t     state, state_nx;
   logic [3:0] bit_cnt, bit_cnt_nx;
   logic [7:0] shift_reg, shift_reg_nx;
   logic [7:0] tx_shift, tx_shift_nx;
   logic       rw, rw_nx;
   logic       oe, oe_nx;
   logic       busy_nx;
   logic [7:0] data_received_nx;
   logic       rx_valid_nx, tx_req_nx;
   logic       load_tx;
   logic [7:0] sampled_byte;

   logic [1:0] scl_sync, sda_sync;
   logic       scl_filt, sda_filt;
   logic       scl_prev, sda_prev;
   logic       scl_rise, scl_fall, start_det, stop_det;

   // Synchronizers reset to the idle-bus level so no false edge follows reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda};
      end
   end

`ifdef I2C_RESPONDER_FILTER_EN
   logic [1:0] scl_hist, sda_hist;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[1]};
         sda_hist <= {sda_hist[0], sda_sync[1]};
         scl_filt <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
         sda_filt <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
      end
   end
`else
   assign scl_filt = scl_sync[1];
   assign sda_filt = sda_sync[1];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl_filt;
         sda_prev <= sda_filt;
      end
   end

   assign scl_rise  = scl_filt & ~scl_prev;
   assign scl_fall  = ~scl_filt & scl_prev;
   assign start_det = scl_filt & scl_prev & sda_prev & ~sda_filt;
   assign stop_det  = scl_filt & scl_prev & ~sda_prev & sda_filt;

   assign sampled_byte = {shift_reg[6:0], sda_filt};

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         tx_shift      <= '0;
         rw            <= 1'b0;
         oe            <= 1'b0;
         busy          <= 1'b0;
         data_received <= '0;
         rx_valid      <= 1'b0;
         tx_req        <= 1'b0;
      end else begin
         state         <= state_nx;
         bit_cnt       <= bit_cnt_nx;
         shift_reg     <= shift_reg_nx;
         tx_shift      <= tx_shift_nx;
         rw            <= rw_nx;
         oe            <= oe_nx;
         busy          <= busy_nx;
         data_received <= data_received_nx;
         rx_valid      <= rx_valid_nx;
         tx_req        <= tx_req_nx;
      end
   end

   always_comb begin
      state_nx         = state;
      bit_cnt_nx       = bit_cnt;
      shift_reg_nx     = shift_reg;
      tx_shift_nx      = tx_shift;
      rw_nx            = rw;
      oe_nx            = oe;
      busy_nx          = busy;
      data_received_nx = data_received;
      rx_valid_nx      = 1'b0;
      tx_req_nx        = 1'b0;
      load_tx          = 1'b0;

      if (stop_det) begin
         state_nx   = IDLE;
         bit_cnt_nx = '0;
         oe_nx      = 1'b0;
         busy_nx    = 1'b0;
      end else if (start_det) begin
         state_nx     = ADDR;
         bit_cnt_nx   = '0;
         shift_reg_nx = '0;
         oe_nx        = 1'b0;
         busy_nx      = 1'b0;
      end else begin
         unique case (state)
            IDLE: oe_nx = 1'b0;
            ADDR: begin
               oe_nx = 1'b0;
               if (scl_rise) begin
                  shift_reg_nx = sampled_byte;
                  bit_cnt_nx   = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt_nx = '0;
                     if (sampled_byte[7:1] == SLAVE_ADDRESS) begin
                        state_nx = ADDR_ACK;
                        rw_nx    = sampled_byte[0];
                        busy_nx  = 1'b1;
                     end else begin
                        state_nx = IDLE;
                     end
                  end
               end
            end
            // First falling edge starts the ACK, the second one ends it.
            ADDR_ACK, WR_ACK: begin
               if (scl_fall) begin
                  if (!oe) begin
                     oe_nx = 1'b1;
                  end else if (state == WR_ACK || !rw) begin
                     oe_nx    = 1'b0;
                     state_nx = WR_DATA;
                  end else begin
                     load_tx = 1'b1;
                  end
               end
            end
            WR_DATA: begin
               oe_nx = 1'b0;
               if (scl_rise) begin
                  shift_reg_nx = sampled_byte;
                  bit_cnt_nx   = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt_nx       = '0;
                     data_received_nx = sampled_byte;
                     rx_valid_nx      = 1'b1;
                     state_nx         = WR_ACK;
                  end
               end
            end
            RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_nx = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_nx      = 1'b0;
                     bit_cnt_nx = '0;
                     state_nx   = RD_ACK;
                  end else begin
                     oe_nx       = ~tx_shift[7];
                     tx_shift_nx = {tx_shift[6:0], 1'b0};
                  end
               end
            end
            // bit_cnt == 1 marks "master ACKed, next byte due on this fall".
            RD_ACK: begin
               oe_nx = 1'b0;
               if (scl_rise) begin
                  if (!sda_filt) begin
                     bit_cnt_nx = 4'd1;
                  end else begin
                     busy_nx  = 1'b0;
                     state_nx = IDLE;
                  end
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  load_tx = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase

         if (load_tx) begin
            tx_shift_nx = {tx_data[6:0], 1'b0};
            oe_nx       = ~tx_data[7];
            tx_req_nx   = 1'b1;
            bit_cnt_nx  = '0;
            state_nx    = RD_DATA;
         end
      end
   end

   assign sda = oe ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_responder.md
I2C_RESPONDER -- requirements
Module: i2c_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h2A, the 7-bit address this target answers to.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port scl  input  1  I2C clock from the master; this block never drives it.
REQ-005 SHALL have port sda  inout  1  I2C data, open-drain: driven 1'b0 or high-Z, never 1'b1.
REQ-006 SHALL have port tx_data  input  8  byte returned on the next master read.
REQ-007 SHALL have port data_received  output  8  last byte written by the master.
REQ-008 SHALL have port rx_valid  output  1  one-clk pulse when data_received updates.
REQ-009 SHALL have port tx_req  output  1  one-clk pulse when tx_data is latched for transmission.
REQ-010 SHALL have port busy  output  1  high from address match until STOP, repeated START or NACKed read.

Function
REQ-011 SHALL pass scl and sda through a 2-flop synchronizer; edges and conditions are detected on synchronized values only.
REQ-012 SHALL detect START as sda falling while scl high, and STOP as sda rising while scl high.
REQ-013 SHALL have states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-014 SHALL go to ADDR with bit counter cleared on START in any state, including a repeated START mid-byte.
REQ-015 SHALL go to IDLE, release sda and clear busy on STOP in any state.
REQ-016 SHALL sample sda on each scl rising edge, MSB first; 8 samples form one byte.
REQ-017 SHALL, in ADDR after the 8th bit, compare bits[7:1] with SLAVE_ADDRESS and take bit[0] as R/W (1 = read).
REQ-018 SHALL, on an address match, drive sda low from the next scl falling edge to the following scl falling edge (ACK), and set busy.
REQ-019 SHALL, on an address mismatch, leave sda released and return to IDLE.
REQ-020 SHALL, after a write ACK, go to WR_DATA; after each 8 data bits, load data_received, pulse rx_valid for one clk on the 8th scl rising edge, and ACK as in REQ-018.
REQ-021 SHALL, for a read, latch tx_data and pulse tx_req on the scl falling edge that ends the ACK slot.
REQ-022 SHALL, in RD_DATA, drive sda low for a 0 bit and release it for a 1 bit, MSB first, with each bit changing only on scl falling edges.
REQ-023 SHALL, in RD_ACK, release sda and sample the master's ACK on the 9th scl rising edge.
REQ-024 SHALL, after a master ACK (sda 0) in RD_ACK, latch the next byte per REQ-021.
REQ-025 SHALL, after a master NACK (sda 1) in RD_ACK, clear busy and go to IDLE.
REQ-026 SHALL hold sda released in IDLE, ADDR and WR_DATA.
REQ-027 SHALL change sda no later than 4 clk after the scl falling edge that causes the change.

Reset
REQ-028 SHALL, while reset is high, go to IDLE, release sda, set data_received=0, rx_valid=0, tx_req=0, busy=0, and clear the bit counter and shift register.
REQ-029 SHALL treat reset mid-transaction the same way, releasing sda within 1 clk, and then ignore the bus until the next START.

Configuration
REQ-030 SHALL add a glitch filter when macro I2C_RESPONDER_FILTER_EN is defined: a 3-sample majority vote on synchronized scl and sda, adding 2 clk of detection latency.
REQ-031 SHALL, without I2C_RESPONDER_FILTER_EN, use the 2-flop synchronized values directly; all other behaviour is identical.

Verification
REQ-032 SHALL check a basic write: START, 0x54 (0x2A+W), 0xA5, STOP -> sda low in both ACK slots, data_received=0xA5, rx_valid high exactly 1 clk, busy low after STOP.
REQ-033 SHALL check a wrong address: START, 0x2A (0x15+W), 0xFF -> sda high in all 9th-clock slots, no rx_valid, busy stays 0.
REQ-034 SHALL check a read: tx_data=0x3C, START, 0x55, master ACKs byte 1, tx_data=0xC3, master NACKs byte 2 -> sda bits 00111100 then 11000011, tx_req pulses twice, sda released after the NACK, busy 0.
REQ-035 SHALL check a repeated START after 4 data bits of a write, then 0x55 -> partial byte discarded, no rx_valid, ACK given, transfer continues as a read.
REQ-036 SHALL check reset asserted while sda is driven low during an ACK -> sda released within 1 clk, all outputs 0, next START+0x54 is ACKed normally.
REQ-037 SHALL check a 1-clk sda glitch while scl is high, with I2C_RESPONDER_FILTER_EN defined -> no START or STOP detected; without the macro -> START is detected.
